present_key_schedule: RTL and testbench

Iterative PRESENT key schedule. It holds the cipher key register and presents one 64-bit round key per round to the addRoundKey stage. That stage sits directly upstream of the substitution layer built from present_sbox instances. Each advance applies one PRESENT key-update step, and the step itself instantiates present_sbox for the top nibble(s).

---
 rtl/present_key_schedule.sv | 127 ++++++++++++
 tb/tb_present_key_schedule.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/present_key_schedule.sv
// Iterative PRESENT key schedule (80/128-bit): holds the key register and
// presents one 64-bit round key per round, advancing on next.

module present_sbox (
    input  logic [3:0] nib,
    output logic [3:0] sub
);
    // PRESENT 4-bit substitution table
    always_comb begin
        sub = 4'h0;
        case (nib)
            4'h0: sub = 4'hC;
            4'h1: sub = 4'h5;
            4'h2: sub = 4'h6;
            4'h3: sub = 4'hB;
            4'h4: sub = 4'h9;
            4'h5: sub = 4'h0;
            4'h6: sub = 4'hA;
            4'h7: sub = 4'hD;
            4'h8: sub = 4'h3;
            4'h9: sub = 4'hE;
            4'hA: sub = 4'hF;
            4'hB: sub = 4'h8;
            4'hC: sub = 4'h4;
            4'hD: sub = 4'h7;
            4'hE: sub = 4'h1;
            default: sub = 4'h2;
        endcase
    end
endmodule

module present_key_schedule #(
    parameter int unsigned KEY_WIDTH = 80,
    parameter int unsigned NROUNDS   = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 next,
    output logic [63:0]          rkey,
    output logic                 rkey_valid,
    output logic [5:0]           round,
    output logic                 last
);
    // Round counter lands on [19:15] for 80-bit keys, [66:62] for 128-bit keys
    localparam int unsigned CTR_LSB    = (KEY_WIDTH == 128) ? 62 : 15;
    localparam logic [5:0]  LAST_ROUND = 6'(NROUNDS + 1);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_width
        $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state, state_n;
    logic [KEY_WIDTH-1:0] key_reg, key_n;
    logic [KEY_WIDTH-1:0] rot, upd;
    logic [5:0]           round_n;
    logic                 valid_n, last_n;
    logic [3:0]           sb0_out, sb1_in, sb1_out;

    // Rotate left by 61
    assign rot    = {key_reg[KEY_WIDTH-62:0], key_reg[KEY_WIDTH-1:KEY_WIDTH-61]};
    // Second S-box only carries data for 128-bit keys
    assign sb1_in = (KEY_WIDTH == 128) ? rot[KEY_WIDTH-5 -: 4] : 4'h0;

    present_sbox u_sbox0 (.nib(rot[KEY_WIDTH-1 -: 4]), .sub(sb0_out));
    present_sbox u_sbox1 (.nib(sb1_in),                .sub(sb1_out));

    // One key-update step: substitute top nibble(s), then fold in round counter
    always_comb begin
        upd = rot;
        upd[KEY_WIDTH-1 -: 4] = sb0_out;
        if (KEY_WIDTH == 128) begin
            upd[KEY_WIDTH-5 -: 4] = sb1_out;
        end
        upd[CTR_LSB +: 5] = upd[CTR_LSB +: 5] ^ round[4:0];
    end

    // Next-state and next-output logic; load wins over next
    always_comb begin
        state_n = state;
        key_n   = key_reg;
        round_n = round;
        valid_n = rkey_valid;
        last_n  = last;
        if (load) begin
            state_n = ACTIVE;
            key_n   = key;
            round_n = 6'd1;
            valid_n = 1'b1;
            last_n  = (LAST_ROUND == 6'd1);
        end else if (state == ACTIVE && next) begin
            if (last) begin
                state_n = IDLE;
                round_n = 6'd0;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end else begin
                key_n   = upd;
                round_n = round + 6'd1;
                last_n  = ((round + 6'd1) == LAST_ROUND);
            end
        end
    end

    // State, key and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_reg    <= '0;
            round      <= 6'd0;
            rkey_valid <= 1'b0;
            last       <= 1'b0;
        end else begin
            state      <= state_n;
            key_reg    <= key_n;
            round      <= round_n;
            rkey_valid <= valid_n;
            last       <= last_n;
        end
    end

    assign rkey = key_reg[KEY_WIDTH-1 -: 64];

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed bench for present_key_schedule: 80-bit and 128-bit instances
// driven in lockstep, checked against constants, a key-update model and
// the published PRESENT-80 cipher vectors.

module tb_present_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         next = 1'b0;
    logic [79:0]  key80 = '0;
    logic [127:0] key128 = '0;

    logic [63:0]  rkey80, rkey128;
    logic         valid80, valid128, last80, last128;
    logic [5:0]   round80, round128;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    present_key_schedule #(.KEY_WIDTH(80), .NROUNDS(31)) dut80 (
        .clk(clk), .rst_n(rst_n), .load(load), .key(key80), .next(next),
        .rkey(rkey80), .rkey_valid(valid80), .round(round80), .last(last80)
    );

    present_key_schedule #(.KEY_WIDTH(128), .NROUNDS(31)) dut128 (
        .clk(clk), .rst_n(rst_n), .load(load), .key(key128), .next(next),
        .rkey(rkey128), .rkey_valid(valid128), .round(round128), .last(last128)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [79:0] upd80(input logic [79:0] k, input int r);
        logic [79:0] t;
        t = (k << 61) | (k >> 19);
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ 5'(r);
        return t;
    endfunction

    function automatic logic [127:0] upd128(input logic [127:0] k, input int r);
        logic [127:0] t;
        t = (k << 61) | (k >> 67);
        t[127:124] = sbox(t[127:124]);
        t[123:120] = sbox(t[123:120]);
        t[66:62]   = t[66:62] ^ 5'(r);
        return t;
    endfunction

    // PRESENT encryption using 32 round keys captured from the DUT
    function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [63:0] rk [32]);
        logic [63:0] s, p;
        s = pt;
        for (int r = 0; r < 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            p = '0;
            for (int j = 0; j < 63; j++) p[(16*j) % 63] = s[j];
            p[63] = s[63];
            s = p;
        end
        return s ^ rk[31];
    endfunction

    // Full 32-key run with next held high; compares both instances to the model
    task automatic full_run(input logic [79:0] k80, input logic [127:0] k128,
                            input logic [63:0] exp_ct, input string tag);
        logic [79:0]  m80;
        logic [127:0] m128;
        logic [63:0]  rk [32];
        int           n_last;
        m80 = k80; m128 = k128; n_last = 0;
        key80 = k80; key128 = k128; load = 1'b1;
        step();
        load = 1'b0; next = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            check({tag, "_rkey80"},  128'(rkey80),  128'(m80[79:16]));
            check({tag, "_rkey128"}, 128'(rkey128), 128'(m128[127:64]));
            check({tag, "_round"},   128'(round80), 128'(i));
            check({tag, "_last"},    128'({last80, last128}), 128'((i == 32) ? 2'b11 : 2'b00));
            if (last80) n_last++;
            rk[i-1] = rkey80;
            m80  = upd80(m80, i);
            m128 = upd128(m128, i);
            step();
        end
        next = 1'b0;
        check({tag, "_last_once"}, 128'(n_last), 128'(1));
        check({tag, "_done_valid"}, 128'({valid80, valid128}), 128'(0));
        check({tag, "_done_round"}, 128'({round80, round128}), 128'(0));
        check({tag, "_cipher"}, 128'(encrypt(64'h0, rk)), 128'(exp_ct));
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("reset_rkey",  128'({rkey80, rkey128}), 128'(0));
            check("reset_flags", 128'({valid80, last80, valid128, last128}), 128'(0));
            check("reset_round", 128'({round80, round128}), 128'(0));
            step();
        end
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        check("idle_next_valid", 128'({valid80, valid128}), 128'(0));
        check("idle_next_round", 128'({round80, round128}), 128'(0));

        // Zero key: load then a single update
        key80 = '0; key128 = '0; load = 1'b1;
        step();
        load = 1'b0;
        check("zero_k1_80",    128'(rkey80), 128'(0));
        check("zero_k1_round", 128'(round80), 128'(1));
        check("zero_k1_valid", 128'({valid80, valid128}), 128'(2'b11));
        next = 1'b1;
        step();
        next = 1'b0;
        check("zero_k2_80",    128'(rkey80),  128'(64'hC000000000000000));
        check("zero_k2_128",   128'(rkey128), 128'(64'hCC00000000000000));
        check("zero_k2_round", 128'(round80), 128'(2));
        step();
        check("zero_hold_80", 128'(rkey80), 128'(64'hC000000000000000));

        // All-ones key: first update
        key80 = '1; key128 = '1; load = 1'b1;
        step();
        load = 1'b0;
        check("ones_k1_80", 128'(rkey80), 128'(64'hFFFFFFFFFFFFFFFF));
        next = 1'b1;
        step();
        next = 1'b0;
        check("ones_k2_80", 128'(rkey80), 128'(64'h2FFFFFFFFFFFFFFF));

        // Full schedules, checked through the published PRESENT-80 vectors
        full_run(80'h0, 128'h0, 64'h5579C1387B228445, "run0");
        full_run('1, 128'h0123456789ABCDEF_FEDCBA9876543210, 64'hE72C46C0F5945049, "run1");

        // Reload at round 17 with next in the same cycle
        key80 = 80'hA5A5_5A5A_0F0F_F0F0_1234; key128 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        load = 1'b1;
        step();
        load = 1'b0; next = 1'b1;
        repeat (16) step();
        next = 1'b0;
        check("pre_reload_round", 128'(round80), 128'(17));
        key80 = 80'h0123456789ABCDEF0123; key128 = 128'hFEDCBA98765432100011223344556677;
        load = 1'b1; next = 1'b1;
        step();
        load = 1'b0; next = 1'b0;
        check("reload_round",   128'({round80, round128}), 128'({6'd1, 6'd1}));
        check("reload_rkey80",  128'(rkey80),  128'(64'h0123456789ABCDEF));
        check("reload_rkey128", 128'(rkey128), 128'(64'hFEDCBA9876543210));
        next = 1'b1;
        step();
        next = 1'b0;
        check("reload_k2_80",  128'(rkey80),  128'(upd80(80'h0123456789ABCDEF0123, 1) >> 16));
        check("reload_k2_128", 128'(rkey128), 128'(upd128(128'hFEDCBA98765432100011223344556677, 1) >> 64));

        // Short asynchronous reset pulse at round 9
        next = 1'b1;
        repeat (7) step();
        next = 1'b0;
        check("pre_reset_round", 128'(round80), 128'(9));
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_rkey",  128'({rkey80, rkey128}), 128'(0));
        check("async_rst_flags", 128'({valid80, last80, round80, valid128, last128, round128}), 128'(0));
        #2 rst_n = 1'b1;
        step();
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        check("post_rst_idle",  128'({valid80, round80, valid128, round128}), 128'(0));
        check("post_rst_rkey",  128'({rkey80, rkey128}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
